// File: rtl/spmm_lhs_loader_pkg.sv
// Shared types and constants for the SpMM LHS path.
// Reused by the SpMM array and its loader.
package spmm_lhs_loader_pkg;

  localparam int SPMM_N     = 16;
  localparam int SPMM_W     = 8;
  localparam int SPMM_LGN   = $clog2(SPMM_N);
  localparam int SPMM_DBLGN = 2 * SPMM_LGN;
  localparam int SPMM_NN    = SPMM_N * SPMM_N;

  typedef logic [SPMM_W-1:0] data_t;

  typedef enum logic [1:0] {
    S_LOAD,
    S_FINAL,
    S_WAIT,
    S_STREAM
  } lhs_state_e;

endpackage

// File: rtl/spmm_lhs_loader_beat_buffer.sv
// N*N-entry col/data store: one write port,
// one N-lane aligned read port.
module lhs_beat_buffer
  import spmm_lhs_loader_pkg::*;
#(
  parameter int N = SPMM_N,
  parameter int W = SPMM_W,
  localparam int LG = $clog2(N),
  localparam int DLG = 2 * LG
) (
  input  logic                   clock,
  input  logic                   we,
  input  logic [DLG-1:0]         waddr,
  input  logic [LG-1:0]          wcol,
  input  logic [W-1:0]           wdata,
  input  logic [LG-1:0]          rbeat,
  output logic [N-1:0][LG-1:0]   rcol,
  output logic [N-1:0][W-1:0]    rdata
);

  logic [LG-1:0] col_mem  [N*N];
  logic [W-1:0]  data_mem [N*N];

  // Stale slots are never cleared; the reader masks the tail.
  always_ff @(posedge clock) begin
    if (we) begin
      col_mem[waddr]  <= wcol;
      data_mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rcol  = '0;
    rdata = '0;
    for (int i = 0; i < N; i++) begin
      rcol[i]  = col_mem[{rbeat, LG'(i)}];
      rdata[i] = data_mem[{rbeat, LG'(i)}];
    end
  end

endmodule

// File: rtl/spmm_lhs_loader.sv
// Collects one sparse LHS matrix, builds CSR row-end
// pointers and streams N-lane beats into the SpMM array.
module spmm_lhs_loader
  import spmm_lhs_loader_pkg::*;
#(
  parameter int N = SPMM_N,
  parameter int W = SPMM_W,
  localparam int LG = $clog2(N),
  localparam int DLG = 2 * LG,
  localparam int CW = DLG + 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LG-1:0]          in_row,
  input  logic [LG-1:0]          in_col,
  input  logic [W-1:0]           in_data,
  input  logic                   in_last,
  input  logic                   lhs_ready_ns,
  output logic                   lhs_start,
  output logic                   lhs_ws,
  output logic                   lhs_os,
  output logic [N-1:0][DLG-1:0]  lhs_ptr,
  output logic [N-1:0][LG-1:0]   lhs_col,
  output logic [N-1:0][W-1:0]    lhs_data,
  output logic                   busy,
  output logic [CW-1:0]          nnz,
  output logic                   err
);

  localparam int NN = N * N;

  lhs_state_e state;

  logic [CW-1:0]  cnt;
  logic [DLG-1:0] cnt_m1;
  logic [LG-1:0]  prev_row;
  logic [LG:0]    beat;
  logic [LG:0]    nbeats;
  logic           accept;
  logic           take;
  logic [LG-1:0]  rd_beat;

  logic [N-1:0][LG-1:0] rd_col;
  logic [N-1:0][W-1:0]  rd_data;
  logic [N-1:0][LG-1:0] beat_col;
  logic [N-1:0][W-1:0]  beat_data;

  assign lhs_ws = 1'b0;
  assign lhs_os = 1'b0;

  assign accept = in_valid && in_ready;
  assign take   = accept && (cnt != CW'(NN));
  // Wraps to NN-1 when the buffer is exactly full.
  assign cnt_m1 = cnt[DLG-1:0] - DLG'(1);
  assign nbeats = (LG+1)'((nnz + CW'(N - 1)) >> LG);
  assign rd_beat = (state == S_STREAM) ? beat[LG-1:0] : '0;

  lhs_beat_buffer #(
    .N (N),
    .W (W)
  ) u_buf (
    .clock (clock),
    .we    (take),
    .waddr (cnt[DLG-1:0]),
    .wcol  (in_col),
    .wdata (in_data),
    .rbeat (rd_beat),
    .rcol  (rd_col),
    .rdata (rd_data)
  );

  // Lanes past nnz read as zero in the last beat.
  always_comb begin
    beat_col  = '0;
    beat_data = '0;
    for (int i = 0; i < N; i++) begin
      if (CW'({rd_beat, LG'(i)}) < nnz) begin
        beat_col[i]  = rd_col[i];
        beat_data[i] = rd_data[i];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_LOAD;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      cnt       <= '0;
      prev_row  <= '0;
      beat      <= '0;
      nnz       <= '0;
      err       <= 1'b0;
      lhs_start <= 1'b0;
      lhs_ptr   <= '0;
      lhs_col   <= '0;
      lhs_data  <= '0;
    end else begin
      lhs_start <= 1'b0;
      unique case (state)
        S_LOAD: begin
          in_ready <= 1'b1;
          if (accept) begin
            if (!take || (cnt != '0 && in_row < prev_row))
              err <= 1'b1;
            if (take) begin
              // First element of a matrix clears stale pointers.
              for (int r = 0; r < N; r++) begin
                if (cnt == '0)
                  lhs_ptr[r] <= '0;
                else if (LG'(r) > prev_row && LG'(r) < in_row)
                  lhs_ptr[r] <= cnt_m1;
              end
              lhs_ptr[in_row] <= cnt[DLG-1:0];
              prev_row <= in_row;
              cnt <= cnt + CW'(1);
            end
            if (in_last) begin
              state    <= S_FINAL;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end
          end
        end
        S_FINAL: begin
          for (int r = 0; r < N; r++) begin
            if (LG'(r) > prev_row)
              lhs_ptr[r] <= cnt_m1;
          end
          nnz   <= cnt;
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (lhs_ready_ns) begin
            lhs_start <= 1'b1;
            lhs_col   <= beat_col;
            lhs_data  <= beat_data;
            beat      <= (LG+1)'(1);
            state     <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (beat < nbeats) begin
            lhs_col  <= beat_col;
            lhs_data <= beat_data;
            beat     <= beat + (LG+1)'(1);
          end else begin
            state    <= S_LOAD;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: doc/spmm_lhs_loader.md
# spmm_lhs_loader

Upstream feeder for the SpMM array. Accepts one LHS sparse matrix as a row-major stream of (row, col, value) nonzeros, builds the CSR row-end pointer vector, and packs values into N-lane beats. On `lhs_ready_ns` it pulses `lhs_start` and streams the beats into SpMM's `lhs_ptr`/`lhs_col`/`lhs_data` inputs, holding `lhs_ptr` stable for the whole transfer.

## Interface
- N, 16, matrix dimension and lanes per beat; power of 2, ≥4
- W, 8, data width
- clock  in  1  single clock, posedge
- reset  in  1  asynchronous, active-low
- in_valid  in  1  nonzero present
- in_ready  out  1  loader accepts; reset 0
- in_row  in  lgN  row index, nondecreasing within a matrix
- in_col  in  lgN  column index
- in_data  in  W  value (data_t)
- in_last  in  1  final nonzero of matrix; every matrix has ≥1 nonzero
- lhs_ready_ns  in  1  SpMM ready for non-stationary LHS
- lhs_start  out  1  one-cycle pulse with beat 0; reset 0
- lhs_ws, lhs_os  out  1  tied 0
- lhs_ptr  out  [N] x dbLgN  row-end pointers; reset all 0
- lhs_col  out  [N] x lgN  beat columns; reset all 0
- lhs_data  out  [N] x W  beat values; reset all 0
- busy  out  1  high outside LOAD; reset 0
- nnz  out  dbLgN+1  nonzeros of held matrix; reset 0
- err  out  1  sticky protocol error; cleared only by reset; reset 0

## Operation
- States: LOAD -> FINAL -> WAIT -> STREAM -> LOAD. Reset enters LOAD and clears counters, pointers, buffer valid.
- LOAD: `in_ready`=1. On each in_valid&&in_ready, write (col, data) to slot `cnt`, set ptr[in_row]=cnt, then cnt++. If in_row > previous row, rows strictly between receive ptr = cnt-1 (previous last index). in_last -> FINAL.
- Row ordering: in_row < previous row sets err; element still stored. cnt reaching N*N with further input: element dropped, err set.
- FINAL (1 cycle): rows above the last row get ptr = nnz-1; leading empty rows hold 0; lanes from nnz up to the next multiple of N are zero-filled (col 0, data 0). nnz latched.
- WAIT: outputs hold. When lhs_ready_ns=1 -> STREAM.
- STREAM: beats B = ceil(nnz/N). Beat k drives slots kN..kN+N-1 on lhs_col/lhs_data. `lhs_start`=1 only in the beat-0 cycle. After beat B-1 -> LOAD. lhs_ptr constant from FINAL until next matrix's first accepted element.
- Deasserting lhs_ready_ns mid-STREAM is ignored; the transfer completes.
- Pointer width: ptr values ≤ N*N-1 fit dbLgN; nnz needs dbLgN+1 (nnz=N*N).

## Timing
- One nonzero per cycle in LOAD; in_ready low in FINAL/WAIT/STREAM.
- in_last accepted at edge t -> FINAL during t+1 -> WAIT at t+2 with lhs_ptr valid.
- lhs_ready_ns sampled in WAIT at edge e -> beat 0 and lhs_start registered, visible after e; beats on consecutive cycles, no gaps.
- in_ready rises the cycle after the final beat; back-to-back matrices lose one cycle.
- All outputs registered.
- Reset mid-STREAM: outputs zero asynchronously and lhs_start drops; the partial matrix is discarded.

## Structure
- Shared package: `data_t`, N/W/lgN/dbLgN constants, state enum. The package is reused by SpMM.
- One sub-module, `lhs_beat_buffer`: N*N-entry col/data storage. It has one write port and one N-wide aligned read port.
- Pointer fill and FSM stay in the top.

## Test plan
- N=16, diagonal (r, r, r+1) for r=0..15 with last on r=15 -> ptr[r]=r, nnz=16, one beat, lhs_data[i]=i+1, lhs_start on that beat only.
- Row 0: 20 nonzeros in cols 0..15 then 0..3, rows 1..15 empty -> ptr = all 19, B=2, beat 1 lanes 4..15 zero.
- Rows 2 and 9 only, 3 elements each -> ptr[0..1]=0, ptr[2..8]=2, ptr[9..15]=5.
- Row sequence 3 then 1 -> err=1 and stays 1 through the next matrix until reset.
- Hold lhs_ready_ns=0 for 10 cycles in WAIT -> outputs stable, no lhs_start. Raise it -> B consecutive beats.
- Assert reset (low) during beat 1 of a 2-beat transfer -> all outputs 0. Deassert -> in_ready=1 next cycle, nnz=0.
